// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 -- 8N1 UART receiver feeding the PIC16F628A USART receive path.
//
// Synchronises the asynchronous rxd pin, oversamples each bit with a prescaled
// tick, validates start and stop bits and hands bytes over through a 2-entry
// FIFO that mirrors the PIC's RCREG double buffer.
//
// Ports:
//   clk          system clock (single domain)
//   rst          asynchronous reset, active-high
//   rxd          raw serial input, idle high
//   rx_data      byte at the FIFO head, meaningful while rx_valid=1
//   rx_valid     FIFO not empty
//   rx_ready     pop strobe, taken when rx_valid && rx_ready at a clk edge
//   framing_err  sticky: a stop bit was sampled low
//   overrun_err  sticky: a byte arrived while the FIFO was full
//   err_clr      one-cycle pulse clearing both error flags
//   busy         receiver is not idle
module uart_rx_8n1 #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun_err,
  input  logic       err_clr,
  output logic       busy
);

  localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                rxd_s_q, rxd_s_d;
  logic                rxd_prev_q, rxd_prev_d;
  logic [1:0]          flush_q, flush_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          mem0_q, mem0_d;
  logic [7:0]          mem1_q, mem1_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                fe_q, fe_d;
  logic                oe_q, oe_d;

  logic                tick;
  logic                push_req;
  logic                fe_set;
  logic                oe_set;
  logic                pop;
  logic [1:0]          fill;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    mem0_d     = mem0_q;
    mem1_d     = mem1_q;
    cnt_d      = cnt_q;
    push_req   = 1'b0;
    fe_set     = 1'b0;
    oe_set     = 1'b0;
    fill       = cnt_q;

    sync1_d    = rxd;
    rxd_s_d    = sync1_q;
    rxd_prev_d = rxd_s_q;
    // Edge detection is held off until the synchroniser and the previous-value
    // flop carry real line samples, so a line that is low at reset release is
    // not mistaken for a start bit.
    flush_d    = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;

    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if ((flush_q == 2'd3) && rxd_prev_q && !rxd_s_q) begin
          state_d    = S_START;
          div_d      = '0;   // phase-align the tick to the start edge
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_d      = 3'd0;
            state_d    = rxd_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rxd_s_q, shift_q[7:1]};
            bit_d      = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            if (rxd_s_q) begin
              // While an overrun is pending, framed bytes are discarded.
              push_req = !oe_q;
              state_d  = S_IDLE;
            end else begin
              fe_set  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rxd_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // FIFO: pop is applied first so a push into a full FIFO that is being
    // popped in the same cycle succeeds.
    pop = (cnt_q != 2'd0) && rx_ready;
    if (pop) begin
      mem0_d = mem1_q;
      fill   = cnt_q - 2'd1;
    end
    if (push_req) begin
      case (fill)
        2'd0: begin
          mem0_d = shift_q;
          fill   = 2'd1;
        end
        2'd1: begin
          mem1_d = shift_q;
          fill   = 2'd2;
        end
        default: oe_set = 1'b1;
      endcase
    end
    cnt_d = fill;

    // A new error event wins over a coincident clear.
    fe_d = fe_set | (fe_q & ~err_clr);
    oe_d = oe_set | (oe_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      flush_q    <= 2'd0;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      mem0_q     <= 8'h00;
      mem1_q     <= 8'h00;
      cnt_q      <= 2'd0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rxd_s_q    <= rxd_s_d;
      rxd_prev_q <= rxd_prev_d;
      flush_q    <= flush_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
      cnt_q      <= cnt_d;
      fe_q       <= fe_d;
      oe_q       <= oe_d;
    end
  end

  assign rx_data     = mem0_q;
  assign rx_valid    = (cnt_q != 2'd0);
  assign framing_err = fe_q;
  assign overrun_err = oe_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Testbench for uart_rx_8n1 at CLK_HZ=1600000, BAUD=10000, OVERSAMPLE=16
// (10 clocks per tick, 160 clocks per bit). Stimulus is driven #1 after a
// rising edge and outputs are sampled at the same point.
module tb_uart_rx_8n1;

  localparam int BIT = 160;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       overrun_err;
  logic       err_clr;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_rx_8n1 #(
    .CLK_HZ    (1600000),
    .BAUD      (10000),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full 8N1 frame; rx_ready is pulsed for the single cycle whose
  // following edge is pop_at+1 clocks after the frame begins (-1: never).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int c = 0; c < 10 * BIT; c++) begin
      rxd      = bits[c / BIT];
      rx_ready = (c == pop_at);
      @(posedge clk);
      #1;
    end
    rx_ready = 1'b0;
    rxd      = 1'b1;
  endtask

  task automatic pulse_ready;
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_err_clr;
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b want 0", framing_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", overrun_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    send_frame(8'hA5, 1'b1, -1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", rx_data); end
    checks++; if (framing_err !== 1'b0 || overrun_err !== 1'b0) begin errors++; $display("FAIL basic_err: got fe=%b oe=%b want 0 0", framing_err, overrun_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
    pulse_ready;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_pop: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_glitch;
    rxd = 1'b0;
    cycles(10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start: got busy=%b want 1", busy); end
    cycles(30);
    rxd = 1'b1;
    cycles(100);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL glitch_fe: got %b want 0", framing_err); end
    cycles(BIT);
  endtask

  task automatic test_framing;
    send_frame(8'h3C, 1'b0, -1);
    cycles(5);
    checks++; if (framing_err !== 1'b1) begin errors++; $display("FAIL frame_fe: got %b want 1", framing_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_valid: got %b want 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy: got %b want 0", busy); end
    pulse_err_clr;
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL frame_clr: got %b want 0", framing_err); end
    cycles(BIT);
  endtask

  task automatic test_overrun;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", overrun_err); end
    send_frame(8'h33, 1'b1, -1);
    checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun_err); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_first: got %h want 11", rx_data); end
    pulse_ready;
    checks++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_second: got %h v=%b want 22 v=1", rx_data, rx_valid); end
    pulse_ready;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: got valid=%b want 0", rx_valid); end
    pulse_err_clr;
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", overrun_err); end
  endtask

  task automatic test_push_pop;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    // The stop-bit sample lands 1523 clocks into the frame (2-flop sync,
    // one edge-detect clock, then 152 ticks of 10 clocks).
    send_frame(8'h44, 1'b1, 1522);
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL pp_oe: got %b want 0", overrun_err); end
    checks++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin errors++; $display("FAIL pp_head: got %h v=%b want 22 v=1", rx_data, rx_valid); end
    pulse_ready;
    checks++; if (rx_data !== 8'h44 || rx_valid !== 1'b1) begin errors++; $display("FAIL pp_next: got %h v=%b want 44 v=1", rx_data, rx_valid); end
    pulse_ready;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_reset_midframe;
    rxd = 1'b0;
    cycles(BIT);
    rxd = 1'b1;
    cycles(340);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    rxd = 1'b0;
    cycles(3);
    checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst: got busy=%b v=%b want 0 0", busy, rx_valid); end
    rst = 1'b0;
    cycles(2 * BIT);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_lowline: got busy=%b want 0", busy); end
    rxd = 1'b1;
    cycles(BIT);
    send_frame(8'h5A, 1'b1, -1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin errors++; $display("FAIL mid_data: got %h v=%b want 5a v=1", rx_data, rx_valid); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL mid_fe: got %b want 0", framing_err); end
    pulse_ready;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_only: got valid=%b want 0", rx_valid); end
  endtask

  // Reference: a bounded queue of capacity 2; when a byte arrives with the
  // queue full the byte is lost and a sticky flag is raised, and while that
  // flag is up arriving bytes are lost too.
  task automatic test_random;
    logic [7:0] q[$];
    bit         oe;
    logic [7:0] b;
    oe = 1'b0;
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, -1);
      if (!oe) begin
        if (q.size() < 2) q.push_back(b);
        else oe = 1'b1;
      end
      checks++; if (rx_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, rx_valid, (q.size() != 0)); end
      checks++; if (overrun_err !== oe) begin errors++; $display("FAIL rnd_oe[%0d]: got %b want %b", i, overrun_err, oe); end
      if (q.size() != 0) begin
        checks++; if (rx_data !== q[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rx_data, q[0]); end
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_ready;
        if (q.size() != 0) q.delete(0);
      end
      if (oe && $urandom_range(0, 2) == 0) begin
        pulse_err_clr;
        oe = 1'b0;
      end
    end
    while (q.size() != 0) begin
      checks++; if (rx_data !== q[0]) begin errors++; $display("FAIL rnd_drain: got %h want %h", rx_data, q[0]); end
      pulse_ready;
      q.delete(0);
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rnd_end: got valid=%b want 0", rx_valid); end
    pulse_err_clr;
  endtask

  initial begin
    rst      = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    cycles(3);
    test_reset;
    rst = 1'b0;
    cycles(10);
    test_basic;
    test_glitch;
    test_framing;
    test_overrun;
    test_push_pop;
    test_reset_midframe;
    cycles(20);
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
